// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding,
// requester count and the all-released grant pattern.
package rr_arbiter_8_pkg;

  localparam int N_REQ  = 8;
  localparam int ADDR_W = 3;

  localparam logic [N_REQ-1:0] GNT_NONE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Modulo-8 index arithmetic; the carry out of the 3-bit sum is the wrap.
  function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_gnt_decode.sv
// Combinational 3-to-8 active-low grant decoder; all ones when not valid,
// so the registered result can never be multi-hot.
module rr_arbiter_8_gnt_decode
  import rr_arbiter_8_pkg::*;
(
  input  logic [ADDR_W-1:0] gnt_addr,
  input  logic              gnt_valid,
  output logic [N_REQ-1:0]  gnt_n
);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
    assign gnt_n[gi] = ~(gnt_valid && (gnt_addr == ADDR_W'(gi)));
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with active-low requests and registered
// active-low one-hot grant, hold limit and one-cycle bus turnaround.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_REQ-1:0]  req_n,
  input  logic              done,
  output logic [N_REQ-1:0]  gnt_n,
  output logic [ADDR_W-1:0] gnt_addr,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  arb_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] last_reg, last_next;
  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              valid_reg, valid_next;
  logic              timeout_reg, timeout_next;
  logic [N_REQ-1:0]  gnt_n_reg, gnt_n_next;

  logic [N_REQ-1:0]  req_act;
  logic [N_REQ-1:0]  req_rot;
  logic [ADDR_W-1:0] start_idx;
  logic [ADDR_W-1:0] rot_idx;
  logic              rot_hit;
  logic [ADDR_W-1:0] winner;
  logic              owner_drop;
  logic              hold_at_max;
  logic              release_now;

  assign req_act   = ~req_n;
  assign start_idx = wrap_add(last_reg, ADDR_W'(1));

  // Rotate so that bit 0 of req_rot is the requester just after the last owner.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign req_rot[gi] = req_act[wrap_add(start_idx, ADDR_W'(gi))];
  end

  always_comb begin
    rot_hit = 1'b0;
    rot_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        rot_hit = 1'b1;
        rot_idx = ADDR_W'(i);
      end
    end
  end

  assign winner      = wrap_add(start_idx, rot_idx);
  assign owner_drop  = req_n[addr_reg];
  assign hold_at_max = (hold_reg == HOLD_MAX);
  assign release_now = done || owner_drop || hold_at_max;

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    hold_next    = hold_reg;
    addr_next    = addr_reg;
    valid_next   = 1'b0;
    timeout_next = 1'b0;
    if (!en) begin
      // Disable overrides everything, including a pending release or timeout.
      state_next = IDLE;
      hold_next  = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rot_hit) begin
            state_next = GRANT;
            addr_next  = winner;
            last_next  = winner;
            valid_next = 1'b1;
            hold_next  = HOLD_W'(1);
          end
        end
        GRANT: begin
          if (release_now) begin
            state_next   = GAP;
            hold_next    = '0;
            timeout_next = hold_at_max && !done && !owner_drop;
          end else begin
            valid_next = 1'b1;
            hold_next  = hold_reg + HOLD_W'(1);
          end
        end
        GAP: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          hold_next  = '0;
        end
      endcase
    end
  end

  rr_arbiter_8_gnt_decode u_gnt_decode (
    .gnt_addr  (addr_next),
    .gnt_valid (valid_next),
    .gnt_n     (gnt_n_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= ADDR_W'(N_REQ - 1);
      hold_reg    <= '0;
      addr_reg    <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
      gnt_n_reg   <= GNT_NONE;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      hold_reg    <= hold_next;
      addr_reg    <= addr_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
      gnt_n_reg   <= gnt_n_next;
    end
  end

  assign gnt_n     = gnt_n_reg;
  assign gnt_addr  = addr_reg;
  assign gnt_valid = valid_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with a cycle-level reference model of the
// arbitration rules and hand-computed expectations for each scenario.
module tb_rr_arbiter_8;

  localparam int M = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req_n;
  logic       done;
  logic [7:0] gnt_n;
  logic [2:0] gnt_addr;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  rr_arbiter_8 #(.MAX_HOLD(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_n     (req_n),
    .done      (done),
    .gnt_n     (gnt_n),
    .gnt_addr  (gnt_addr),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long, and whether a turnaround is pending.
  typedef struct {
    int owner;
    int last;
    int hold;
    bit gap;
    bit to;
  } model_t;

  function automatic model_t model_reset();
    model_t r;
    r.owner = -1;
    r.last  = 7;
    r.hold  = 0;
    r.gap   = 1'b0;
    r.to    = 1'b0;
    return r;
  endfunction

  function automatic model_t step(input model_t m, input logic e,
                                  input logic [7:0] rq, input logic d);
    model_t n;
    int idx;
    n    = m;
    n.to = 1'b0;
    if (!e) begin
      n.owner = -1;
      n.gap   = 1'b0;
      n.hold  = 0;
    end else if (m.owner >= 0) begin
      if (d || rq[m.owner]) begin
        n.owner = -1;
        n.gap   = 1'b1;
      end else if (m.hold == M) begin
        n.owner = -1;
        n.gap   = 1'b1;
        n.to    = 1'b1;
      end else begin
        n.hold = m.hold + 1;
      end
    end else if (m.gap) begin
      n.gap = 1'b0;
    end else begin
      for (int off = 1; off <= 8; off++) begin
        idx = (m.last + off) % 8;
        if (!rq[idx] && n.owner < 0) begin
          n.owner = idx;
          n.last  = idx;
          n.hold  = 1;
        end
      end
    end
    return n;
  endfunction

  function automatic int exp_gnt_n(input int owner);
    return (owner >= 0) ? ('hFF ^ (1 << owner)) : 'hFF;
  endfunction

  model_t m;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= model_reset();
    else        m <= step(m, en, req_n, done);
  end

  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    chk("model_valid", int'(gnt_valid), int'(m.owner >= 0));
    chk("model_gnt_n", int'(gnt_n), exp_gnt_n(m.owner));
    chk("model_timeout", int'(timeout), int'(m.to));
    if (m.owner >= 0) chk("model_addr", int'(gnt_addr), m.owner);
    if (gnt_valid && !prev_valid)
      $display("grant: requester %0d gnt_n=%02h at %0t", gnt_addr, gnt_n, $time);
    if (timeout)
      $display("timeout: grant revoked at hold limit at %0t", $time);
    prev_valid <= gnt_valid;
  end

  task automatic wait_grant(input int max_cyc, output int addr, output int waited);
    bit found;
    found  = 1'b0;
    addr   = -1;
    waited = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (!found) begin
        @(negedge clk);
        if (gnt_valid) begin
          found  = 1'b1;
          addr   = int'(gnt_addr);
          waited = i;
        end
      end
    end
    if (!found) chk("grant_wait_expired", 0, 1);
  endtask

  task automatic pulse_done();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int addr;
    int waited;
    int cnt;
    int order[$];

    rst_n = 1'b0;
    en    = 1'b1;
    req_n = 8'h00;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_gnt_n", int'(gnt_n), 'hFF);
    chk("reset_valid", int'(gnt_valid), 0);
    chk("reset_timeout", int'(timeout), 0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_addr", int'(gnt_addr), 0);
    chk("first_gnt_n", int'(gnt_n), 'hFE);
    chk("model_pin_first", m.owner, 0);

    // Rotation with all requesting: 0,1,...,7,0, two empty cycles between grants.
    order.push_back(int'(gnt_addr));
    for (int g = 1; g <= 8; g++) begin
      pulse_done();
      chk("rot_gap_valid", int'(gnt_valid), 0);
      wait_grant(8, addr, waited);
      chk("rot_spacing", waited, 2);
      chk("rot_gnt_n", int'(gnt_n), 'hFF ^ (1 << (g % 8)));
      order.push_back(addr);
    end
    for (int g = 0; g < 9; g++) chk("rot_order", order[g], g % 8);

    // Sparse wrap: move ownership to 6, then only 0 and 2 request.
    req_n = 8'hBF;
    pulse_done();
    wait_grant(8, addr, waited);
    chk("sparse_to_6", addr, 6);
    req_n = 8'hFA;
    pulse_done();
    wait_grant(8, addr, waited);
    chk("sparse_wrap_0", addr, 0);
    pulse_done();
    wait_grant(8, addr, waited);
    chk("sparse_then_2", addr, 2);

    // Hold limit: requester 3 never signals done.
    req_n = 8'hF7;
    @(negedge clk);
    wait_grant(8, addr, waited);
    chk("to_owner_3", addr, 3);
    cnt = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!gnt_valid) break;
      cnt++;
    end
    chk("to_hold_cycles", cnt, M);
    chk("to_pulse", int'(timeout), 1);
    chk("to_gnt_n", int'(gnt_n), 'hFF);
    chk("model_pin_timeout", int'(m.to), 1);
    @(negedge clk);
    chk("to_pulse_clear", int'(timeout), 0);

    // done on the last allowed hold cycle is an ordinary release.
    wait_grant(8, addr, waited);
    chk("dmax_owner_3", addr, 3);
    repeat (M - 1) @(negedge clk);
    chk("dmax_still_held", int'(gnt_valid), 1);
    pulse_done();
    chk("dmax_released", int'(gnt_valid), 0);
    chk("dmax_no_timeout", int'(timeout), 0);

    // Owner withdraws its request.
    wait_grant(8, addr, waited);
    chk("wd_owner_3", addr, 3);
    @(negedge clk);
    req_n = 8'hFF;
    @(negedge clk);
    chk("wd_released", int'(gnt_valid), 0);
    chk("wd_no_timeout", int'(timeout), 0);

    // Disable during a grant to 5, together with done.
    req_n = 8'hDF;
    wait_grant(8, addr, waited);
    chk("en_owner_5", addr, 5);
    en    = 1'b0;
    done  = 1'b1;
    req_n = 8'h00;
    @(negedge clk);
    en   = 1'b1;
    done = 1'b0;
    chk("en_gnt_n", int'(gnt_n), 'hFF);
    chk("en_no_timeout", int'(timeout), 0);
    wait_grant(4, addr, waited);
    chk("en_next_6", addr, 6);
    chk("en_regrant_latency", waited, 1);

    // Asynchronous reset in the middle of a grant.
    #2 rst_n = 1'b0;
    #1;
    chk("areset_gnt_n", int'(gnt_n), 'hFF);
    chk("areset_valid", int'(gnt_valid), 0);
    chk("areset_addr", int'(gnt_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_grant(4, addr, waited);
    chk("areset_first_0", addr, 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares one bus/resource between eight active-low requesters. It issues a registered, active-low one-hot grant plus its 3-bit encoded address, so the grant can drive chip-select style enables directly. The block holds a grant until the owner releases it or a hold limit expires. It then rotates priority so that no requester starves. It sits between the requester pool and the shared resource's select logic.

## Interface
- MAX_HOLD, 16, maximum consecutive cycles one grant may be held (legal range 1..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  arbiter enable, active-high; low forces no grant
- req_n  in  8  request lines, active-low, bit i = requester i
- done  in  1  one-cycle release pulse from the current owner
- gnt_n  out  8  grant lines, active-low one-hot; 8'hFF = no grant
- gnt_addr  out  3  index of current owner (valid only when gnt_valid=1)
- gnt_valid  out  1  high while a grant is active
- timeout  out  1  one-cycle pulse when a grant is revoked at MAX_HOLD

## Operation
- States: IDLE, GRANT, GAP.
- Reset (async, rst_n=0):
  - state=IDLE, gnt_n=8'hFF, gnt_addr=0, gnt_valid=0, timeout=0
  - last pointer=7, so the first search starts at 0
  - hold counter=0
- IDLE:
  - If en=1 and any req_n bit is 0, pick the first asserted requester scanning last+1, last+2, … mod 8 (wrap 7→0).
  - Next cycle: state=GRANT, gnt_n bit cleared, gnt_addr=winner, gnt_valid=1, hold counter=1, last=winner.
- GRANT: the release condition is any of the following, evaluated each cycle:
  - done=1
  - the owner's req_n bit=1 (owner withdrew)
  - hold counter==MAX_HOLD
- GRANT, on release:
  - Next cycle: state=GAP, gnt_n=8'hFF, gnt_valid=0.
  - timeout=1 for that cycle only when the release was due to MAX_HOLD alone.
- GRANT, otherwise: hold counter increments.
- GAP:
  - Exactly one cycle with no grant (bus turnaround), then IDLE.
  - IDLE arbitrates the same cycle it is entered, so the minimum re-grant spacing is 2 idle cycles.
- en=0 in any state: next cycle state=IDLE, gnt_n=8'hFF, gnt_valid=0, timeout=0. last is retained, and no timeout is reported.
- done outside GRANT is ignored.
- Requests from non-owners during GRANT are ignored; they are arbitrated in IDLE.
- Hold counter width: ceil(log2(MAX_HOLD+1)); it never exceeds MAX_HOLD.

## Timing
- Grant latency: request sampled at edge k in IDLE → gnt_n/gnt_valid change after edge k (registered outputs, visible cycle k+1).
- Release latency: done at edge k → gnt_n=8'hFF after edge k.
- MAX_HOLD=M: gnt_valid is high for at most M cycles, then GAP with timeout=1 for 1 cycle.
- Simultaneous done and hold==MAX_HOLD: treated as a normal release, timeout=0.
- Simultaneous en=0 and done: en=0 wins, same visible result, timeout=0.
- rst_n asserted mid-grant: outputs go to reset values immediately, without waiting for clk.
- gnt_n is always all-ones or exactly one zero; it never glitches to multi-hot (registered, from a one-hot decode of gnt_addr gated by gnt_valid).

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE=2'd0, GRANT=2'd1, GAP=2'd2)
  - constant N_REQ=8
  - constant GNT_NONE=8'hFF
- One sub-module, gnt_decode: combinational 3-to-8 active-low decoder with enable.
  - Input: gnt_addr, gnt_valid.
  - Output: next gnt_n, all ones when disabled.
- Top level contains the FSM, the rotating-priority search (priority encoder over the rotated req vector), the pointer, the hold counter and the output registers.

## Test plan
- Reset: rst_n=0 with req_n=8'h00 → gnt_n=8'hFF, gnt_valid=0. After release, the first grant goes to requester 0 (gnt_addr=0, gnt_n=8'hFE).
- Rotation: req_n=8'h00 held constant, done pulsed every grant → grant order 0,1,2,…,7,0 with gnt_n 8'hFE, 8'hFD, …, 8'h7F. Each grant is separated by 1 GAP cycle plus 1 IDLE cycle.
- Sparse wrap:
  - Owner=6 releases.
  - Then req_n=8'b1111_1010 (requesters 0 and 2) → grant goes to 0 (wrap 7→0), then to 2.
- Timeout: MAX_HOLD=4, requester 3 holds req without done → gnt_valid high exactly 4 cycles, then timeout=1 for 1 cycle and gnt_n=8'hFF.
- Corner cases:
  - done coincides with the 4th hold cycle → timeout stays 0.
  - Owner deasserts its req_n → release next cycle.
- Enable/reset mid-grant:
  - en=0 during a grant to 5 → gnt_n=8'hFF next cycle, timeout=0.
  - After en=1 with all requests, the next grant is 6.
  - rst_n pulsed asynchronously mid-grant → outputs clear before the next clk edge.
